// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo-core definitions: data-path widths, opcode encodings and the
// ROB entry record.
package tomasulo_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned ROB_AW    = 3;
    localparam int unsigned REG_AW    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned OPC_W     = 4;

    localparam logic [OPC_W-1:0] OP_SUB   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_MUL   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_STORE = 4'b0100;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'b0101;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire.sv
// Reorder buffer retire end: in-order allocation, tagged write-back and
// strictly in-order retirement of one completed entry per cycle.
module rob_retire
    import tomasulo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [OPC_W-1:0]  alloc_opcode,
    input  logic [REG_AW-1:0] alloc_dest,
    output logic [ROB_AW-1:0] alloc_tag,
    input  logic              wb_valid,
    input  logic [ROB_AW-1:0] wb_tag,
    input  logic [DATA_W-1:0] wb_value,
    output logic              wb_err,
    output logic              ret_valid,
    output logic              ret_we,
    output logic [ROB_AW-1:0] ret_tag,
    output logic [REG_AW-1:0] ret_dest,
    output logic [DATA_W-1:0] ret_value,
    output logic [OPC_W-1:0]  ret_opcode,
    output logic [ROB_AW:0]   count,
    output logic              empty
);

    rob_entry_t        rob_q [ROB_DEPTH];
    rob_entry_t        rob_d [ROB_DEPTH];
    logic [ROB_AW-1:0] head_q, head_d;
    logic [ROB_AW-1:0] tail_q, tail_d;
    logic [ROB_AW:0]   count_q, count_d;

    logic              ret_valid_q, ret_valid_d;
    logic              ret_we_q, ret_we_d;
    logic [ROB_AW-1:0] ret_tag_q, ret_tag_d;
    logic [REG_AW-1:0] ret_dest_q, ret_dest_d;
    logic [DATA_W-1:0] ret_value_q, ret_value_d;
    logic [OPC_W-1:0]  ret_opcode_q, ret_opcode_d;
    logic              wb_err_q, wb_err_d;

    logic alloc_fire;
    logic retire_fire;
    logic wb_ok;

    // Full gates allocation on registered count only; a same-cycle retire does not free a slot.
    assign alloc_ready = (count_q != (ROB_AW + 1)'(ROB_DEPTH));
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign retire_fire = rob_q[head_q].busy && rob_q[head_q].done;
    assign wb_ok       = wb_valid && rob_q[wb_tag].busy && !rob_q[wb_tag].done;

    // Alloc targets a non-busy slot, write-back a busy not-done slot, retire a done slot,
    // so the three updates below never touch the same entry.
    always_comb begin
        rob_d        = rob_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ret_valid_d  = 1'b0;
        ret_we_d     = 1'b0;
        ret_tag_d    = ret_tag_q;
        ret_dest_d   = ret_dest_q;
        ret_value_d  = ret_value_q;
        ret_opcode_d = ret_opcode_q;
        wb_err_d     = wb_valid && !wb_ok;

        if (retire_fire) begin
            ret_valid_d          = 1'b1;
            ret_we_d             = (rob_q[head_q].opcode != OP_STORE);
            ret_tag_d            = head_q;
            ret_dest_d           = rob_q[head_q].dest;
            ret_value_d          = rob_q[head_q].value;
            ret_opcode_d         = rob_q[head_q].opcode;
            rob_d[head_q].busy   = 1'b0;
            rob_d[head_q].done   = 1'b0;
            head_d               = head_q + 1'b1;
        end

        if (alloc_fire) begin
            rob_d[tail_q].busy   = 1'b1;
            rob_d[tail_q].done   = 1'b0;
            rob_d[tail_q].opcode = alloc_opcode;
            rob_d[tail_q].dest   = alloc_dest;
            tail_d               = tail_q + 1'b1;
        end

        if (wb_ok) begin
            rob_d[wb_tag].value = wb_value;
            rob_d[wb_tag].done  = 1'b1;
        end

        case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ret_valid_q  <= 1'b0;
            ret_we_q     <= 1'b0;
            ret_tag_q    <= '0;
            ret_dest_q   <= '0;
            ret_value_q  <= '0;
            ret_opcode_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            rob_q        <= rob_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ret_valid_q  <= ret_valid_d;
            ret_we_q     <= ret_we_d;
            ret_tag_q    <= ret_tag_d;
            ret_dest_q   <= ret_dest_d;
            ret_value_q  <= ret_value_d;
            ret_opcode_q <= ret_opcode_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign ret_valid  = ret_valid_q;
    assign ret_we     = ret_we_q;
    assign ret_tag    = ret_tag_q;
    assign ret_dest   = ret_dest_q;
    assign ret_value  = ret_value_q;
    assign ret_opcode = ret_opcode_q;
    assign wb_err     = wb_err_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: reset, retire ordering, full/wrap, store,
// bad write-back and mid-operation reset.
module tb_rob_retire;

    logic       clk;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [3:0] alloc_opcode;
    logic [3:0] alloc_dest;
    logic [2:0] alloc_tag;
    logic       wb_valid;
    logic [2:0] wb_tag;
    logic [7:0] wb_value;
    logic       wb_err;
    logic       ret_valid;
    logic       ret_we;
    logic [2:0] ret_tag;
    logic [3:0] ret_dest;
    logic [7:0] ret_value;
    logic [3:0] ret_opcode;
    logic [3:0] count;
    logic       empty;

    int errors = 0;
    int checks = 0;

    rob_retire dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_opcode (alloc_opcode),
        .alloc_dest   (alloc_dest),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_value     (wb_value),
        .wb_err       (wb_err),
        .ret_valid    (ret_valid),
        .ret_we       (ret_we),
        .ret_tag      (ret_tag),
        .ret_dest     (ret_dest),
        .ret_value    (ret_value),
        .ret_opcode   (ret_opcode),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_opcode = 4'h0;
        alloc_dest   = 4'h0;
        wb_valid     = 1'b0;
        wb_tag       = 3'd0;
        wb_value     = 8'h00;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_tag", 32'(alloc_tag), 32'd0);
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_ret_value", 32'(ret_value), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);

        // Basic allocate / write-back / retire
        alloc_valid = 1'b1; alloc_opcode = 4'b0001; alloc_dest = 4'd3;
        chk("b_alloc_tag", 32'(alloc_tag), 32'd0);
        step();
        alloc_valid = 1'b0;
        chk("b_count1", 32'(count), 32'd1);
        chk("b_empty0", 32'(empty), 32'd0);
        wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 8'h2A;
        step();
        wb_valid = 1'b0;
        chk("b_no_bypass", 32'(ret_valid), 32'd0);
        chk("b_wb_err0", 32'(wb_err), 32'd0);
        step();
        chk("b_ret_valid", 32'(ret_valid), 32'd1);
        chk("b_ret_we", 32'(ret_we), 32'd1);
        chk("b_ret_dest", 32'(ret_dest), 32'd3);
        chk("b_ret_value", 32'(ret_value), 32'h2A);
        chk("b_ret_tag", 32'(ret_tag), 32'd0);
        chk("b_ret_opc", 32'(ret_opcode), 32'd1);
        chk("b_count0", 32'(count), 32'd0);
        step();
        chk("b_pulse", 32'(ret_valid), 32'd0);
        chk("b_hold_value", 32'(ret_value), 32'h2A);

        // In-order retirement
        do_reset();
        alloc_valid = 1'b1; alloc_opcode = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            alloc_dest = 4'(i + 8);
            chk("io_alloc_tag", 32'(alloc_tag), 32'(i));
            step();
        end
        alloc_valid = 1'b0;
        chk("io_count3", 32'(count), 32'd3);
        wb_valid = 1'b1;
        wb_tag = 3'd2; wb_value = 8'h11; step();
        chk("io_no_ret_a", 32'(ret_valid), 32'd0);
        wb_tag = 3'd1; wb_value = 8'h22; step();
        chk("io_no_ret_b", 32'(ret_valid), 32'd0);
        wb_tag = 3'd0; wb_value = 8'h33; step();
        wb_valid = 1'b0;
        chk("io_no_ret_c", 32'(ret_valid), 32'd0);
        step();
        chk("io_r0_valid", 32'(ret_valid), 32'd1);
        chk("io_r0_tag", 32'(ret_tag), 32'd0);
        chk("io_r0_value", 32'(ret_value), 32'h33);
        step();
        chk("io_r1_valid", 32'(ret_valid), 32'd1);
        chk("io_r1_tag", 32'(ret_tag), 32'd1);
        chk("io_r1_value", 32'(ret_value), 32'h22);
        step();
        chk("io_r2_valid", 32'(ret_valid), 32'd1);
        chk("io_r2_tag", 32'(ret_tag), 32'd2);
        chk("io_r2_value", 32'(ret_value), 32'h11);
        chk("io_r2_dest", 32'(ret_dest), 32'd10);
        chk("io_count0", 32'(count), 32'd0);

        // Full and wrap
        do_reset();
        alloc_valid = 1'b1; alloc_opcode = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            alloc_dest = 4'(i);
            chk("fw_alloc_tag", 32'(alloc_tag), 32'(i));
            step();
        end
        chk("fw_count8", 32'(count), 32'd8);
        chk("fw_ready0", 32'(alloc_ready), 32'd0);
        step();
        alloc_valid = 1'b0;
        chk("fw_ignored", 32'(count), 32'd8);
        wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 8'h77;
        step();
        wb_valid = 1'b0;
        chk("fw_ready_still0", 32'(alloc_ready), 32'd0);
        step();
        chk("fw_ret_tag", 32'(ret_tag), 32'd0);
        chk("fw_ret_value", 32'(ret_value), 32'h77);
        chk("fw_count7", 32'(count), 32'd7);
        chk("fw_ready1", 32'(alloc_ready), 32'd1);
        chk("fw_wrap_tag", 32'(alloc_tag), 32'd0);
        alloc_valid = 1'b1; alloc_dest = 4'd15;
        step();
        alloc_valid = 1'b0;
        chk("fw_count8b", 32'(count), 32'd8);
        chk("fw_ready0b", 32'(alloc_ready), 32'd0);

        // Store retire, with an allocation in the retire cycle
        do_reset();
        alloc_valid = 1'b1; alloc_opcode = 4'b0100; alloc_dest = 4'd9;
        step();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 8'h05;
        step();
        wb_valid = 1'b0;
        alloc_valid = 1'b1; alloc_opcode = 4'b0001; alloc_dest = 4'd2;
        step();
        alloc_valid = 1'b0;
        chk("st_ret_valid", 32'(ret_valid), 32'd1);
        chk("st_ret_we", 32'(ret_we), 32'd0);
        chk("st_ret_opc", 32'(ret_opcode), 32'h4);
        chk("st_ret_value", 32'(ret_value), 32'h05);
        chk("st_count_same", 32'(count), 32'd1);
        chk("st_next_tag", 32'(alloc_tag), 32'd2);

        // Bad write-back: head=1 busy, allocate tag2
        alloc_valid = 1'b1; alloc_dest = 4'd6;
        step();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd5; wb_value = 8'hEE;
        step();
        chk("bw_idle_err", 32'(wb_err), 32'd1);
        wb_tag = 3'd2; wb_value = 8'h44;
        step();
        chk("bw_good_noerr", 32'(wb_err), 32'd0);
        wb_tag = 3'd2; wb_value = 8'h99;
        step();
        chk("bw_done_err", 32'(wb_err), 32'd1);
        wb_tag = 3'd1; wb_value = 8'h10;
        step();
        wb_valid = 1'b0;
        chk("bw_err_pulse", 32'(wb_err), 32'd0);
        chk("bw_no_ret", 32'(ret_valid), 32'd0);
        step();
        chk("bw_r1_tag", 32'(ret_tag), 32'd1);
        chk("bw_r1_value", 32'(ret_value), 32'h10);
        step();
        chk("bw_r2_valid", 32'(ret_valid), 32'd1);
        chk("bw_r2_tag", 32'(ret_tag), 32'd2);
        chk("bw_r2_value", 32'(ret_value), 32'h44);
        chk("bw_r2_dest", 32'(ret_dest), 32'd6);
        chk("bw_count0", 32'(count), 32'd0);

        // Reset mid-operation
        do_reset();
        alloc_valid = 1'b1; alloc_opcode = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            alloc_dest = 4'(i);
            step();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        wb_tag = 3'd2; wb_value = 8'hA2; step();
        wb_tag = 3'd3; wb_value = 8'hA3; step();
        wb_valid = 1'b0;
        chk("rm_count4", 32'(count), 32'd4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rm_count0", 32'(count), 32'd0);
        chk("rm_empty", 32'(empty), 32'd1);
        chk("rm_ret_valid", 32'(ret_valid), 32'd0);
        chk("rm_alloc_tag", 32'(alloc_tag), 32'd0);
        wb_valid = 1'b1; wb_tag = 3'd2; wb_value = 8'h55;
        step();
        wb_valid = 1'b0;
        chk("rm_wb_err", 32'(wb_err), 32'd1);
        step();
        chk("rm_no_retire", 32'(ret_valid), 32'd0);
        chk("rm_count_still0", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
